// File: rtl/gat_bram_load_ctrl.sv
// Host-to-core BRAM load bridge: registered per-channel write ports plus a load/start/run/done sequencer.
// Optional macro GAT_LOAD_CNT_EN adds per-channel saturating accepted-write counters on load_cnt.
module gat_bram_load_ctrl #(
  parameter int NUM_CH     = 3,
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_W     = 18,
  parameter int ADDR_LSB   = 2,
  parameter int CNT_W      = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 gat_layer,
  input  logic [NUM_CH*DATA_WIDTH-1:0]         bram_din,
  input  logic [NUM_CH-1:0]                    bram_ena,
  input  logic [NUM_CH-1:0]                    bram_wea,
  input  logic [NUM_CH*(ADDR_W+ADDR_LSB)-1:0]  bram_addra,
  input  logic [NUM_CH-1:0]                    load_done,
  output logic [NUM_CH*DATA_WIDTH-1:0]         core_din,
  output logic [NUM_CH-1:0]                    core_ena,
  output logic [NUM_CH-1:0]                    core_wea,
  output logic [NUM_CH*ADDR_W-1:0]             core_addra,
  output logic                                 core_start,
  output logic                                 core_layer,
  input  logic                                 core_done,
  output logic                                 gat_ready,
  output logic                                 load_err,
  output logic [31:0]                          gat_debug,
  output logic [NUM_CH*CNT_W-1:0]              load_cnt
);

  localparam int HA_W  = ADDR_W + ADDR_LSB;
  localparam int PAD_W = 32 - 16 - NUM_CH - 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e                      state_q, state_d;
  logic [NUM_CH-1:0]           done_q, done_d;
  logic                        load_err_q, load_err_d;
  logic [15:0]                 run_cnt_q, run_cnt_d;
  logic                        core_layer_q, core_layer_d;

  logic [NUM_CH*DATA_WIDTH-1:0] core_din_q;
  logic [NUM_CH*ADDR_W-1:0]     core_addra_q;
  logic [NUM_CH-1:0]            core_ena_q, core_wea_q;

  logic                        wr_open;
  logic [NUM_CH-1:0]           wr_ok, wr_bad;

  // NOTE: every variable driven here gets a default before any branch, so no latch can be inferred.
  always_comb begin
    wr_open = (state_q == IDLE) || (state_q == LOAD) || (state_q == DONE);
    wr_ok   = '0;
    wr_bad  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bram_ena[k] && bram_wea[k]) begin
        if (wr_open && (bram_addra[k*HA_W +: ADDR_LSB] == '0)) wr_ok[k]  = 1'b1;
        else                                                   wr_bad[k] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_din_q   <= '0;
      core_addra_q <= '0;
      core_ena_q   <= '0;
      core_wea_q   <= '0;
    end else begin
      core_din_q <= bram_din;
      for (int k = 0; k < NUM_CH; k++) begin
        core_addra_q[k*ADDR_W +: ADDR_W] <= bram_addra[k*HA_W + ADDR_LSB +: ADDR_W];
        // Reads pass through; a rejected write is suppressed entirely.
        core_ena_q[k] <= bram_ena[k] & ~wr_bad[k];
        core_wea_q[k] <= wr_ok[k];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    load_err_d   = load_err_q | (|wr_bad);
    run_cnt_d    = run_cnt_q;
    core_layer_d = core_layer_q;
    case (state_q)
      IDLE: begin
        done_d = done_q | load_done;
        if ((|wr_ok) || (|load_done)) state_d = LOAD;
      end
      LOAD: begin
        done_d = done_q | load_done;
        if (&(done_q | load_done)) state_d = START;
      end
      START: begin
        core_layer_d = gat_layer;
        state_d      = RUN;
      end
      RUN: begin
        if (core_done) begin
          state_d   = DONE;
          run_cnt_d = run_cnt_q + 16'd1;
        end
      end
      DONE: begin
        // A fresh load round starts with no channel considered finished.
        if ((|wr_ok) || (|load_done)) begin
          state_d = LOAD;
          done_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      done_q       <= '0;
      load_err_q   <= 1'b0;
      run_cnt_q    <= '0;
      core_layer_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      load_err_q   <= load_err_d;
      run_cnt_q    <= run_cnt_d;
      core_layer_q <= core_layer_d;
    end
  end

`ifdef GAT_LOAD_CNT_EN
  logic [NUM_CH*CNT_W-1:0] cnt_q, cnt_d;
  logic                    cnt_clr;

  // The write that triggers entry to LOAD is the first one counted in the new round.
  always_comb begin
    cnt_clr = ((state_q == IDLE) || (state_q == DONE)) && (state_d == LOAD);
    cnt_d   = cnt_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cnt_clr)
        cnt_d[k*CNT_W +: CNT_W] = {{(CNT_W-1){1'b0}}, wr_ok[k]};
      else if (wr_ok[k] && (cnt_q[k*CNT_W +: CNT_W] != '1))
        cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign load_cnt = cnt_q;
`else
  assign load_cnt = '0;
`endif

  assign core_din   = core_din_q;
  assign core_addra = core_addra_q;
  assign core_ena   = core_ena_q;
  assign core_wea   = core_wea_q;
  assign core_start = (state_q == START);
  assign core_layer = core_layer_q;
  assign gat_ready  = (state_q == DONE);
  assign load_err   = load_err_q;
  assign gat_debug  = {run_cnt_q, {PAD_W{1'b0}}, done_q, load_err_q, 3'(state_q)};

endmodule

// File: doc/gat_bram_load_ctrl.md
GAT_BRAM_LOAD_CTRL -- requirements
Module: gat_bram_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning the number of independent BRAM load channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 24, meaning the per-channel write data width.
REQ-003 SHALL have parameter ADDR_W, default 18, meaning the per-channel word-address width at the core side.
REQ-004 SHALL have parameter ADDR_LSB, default 2, meaning the number of byte-offset bits stripped from the host address.
REQ-005 SHALL have parameter CNT_W, default 32, meaning the per-channel write-counter width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port gat_layer, input, 1 bit: layer select from the register bank.
REQ-009 SHALL have port bram_din, input, NUM_CH*DATA_WIDTH bits: host write data; channel k occupies slice k.
REQ-010 SHALL have ports bram_ena and bram_wea, input, NUM_CH bits each: host per-channel enable and write enable.
REQ-011 SHALL have port bram_addra, input, NUM_CH*(ADDR_W+ADDR_LSB) bits: host byte addresses.
REQ-012 SHALL have port load_done, input, NUM_CH bits: per-channel level load-complete flags.
REQ-013 SHALL have ports core_din, core_ena, core_wea and core_addra, outputs with widths NUM_CH*DATA_WIDTH, NUM_CH, NUM_CH and NUM_CH*ADDR_W: the registered write ports to the core BRAMs.
REQ-014 SHALL have ports core_start, output, 1 bit (one-cycle start pulse); core_layer, output, 1 bit (latched layer); and core_done, input, 1 bit (completion pulse).
REQ-015 SHALL have ports gat_ready, output, 1 bit; load_err, output, 1 bit (sticky error); gat_debug, output, 32 bits (status).
REQ-016 SHALL have port load_cnt, output, NUM_CH*CNT_W bits: per-channel accepted-write counts.

Function
REQ-017 SHALL register each channel's write path with exactly 1-cycle latency, driving core_addra[k] = bram_addra[k][ADDR_W+ADDR_LSB-1:ADDR_LSB].
REQ-018 SHALL accept a channel-k write when ena&wea=1, the low ADDR_LSB address bits are 0, and the state is IDLE, LOAD or DONE.
REQ-019 SHALL drop (core_ena[k]=0 next cycle) and set load_err for a write that is unaligned or that occurs in START or RUN.
REQ-020 SHALL pass non-write reads (ena=1, wea=0) through with core_wea=0 and never flag them.
REQ-021 SHALL implement FSM encodings IDLE=0, LOAD=1, START=2, RUN=3, DONE=4.
REQ-022 SHALL, in IDLE or DONE, transition to LOAD on any accepted write or any load_done bit high.
REQ-023 SHALL keep sticky done bits: in IDLE and LOAD, done_q |= load_done; the bits clear on the entry to LOAD taken from DONE.
REQ-024 SHALL, in LOAD, go to START in the cycle after (done_q | load_done) becomes all-ones, including the case where all channels finish in the same cycle.
REQ-025 SHALL, in START, assert core_start for exactly one cycle, latch core_layer = gat_layer, then go to RUN.
REQ-026 SHALL, in RUN, go to DONE on core_done; core_done in any other state is ignored.
REQ-027 SHALL hold gat_ready=1 in DONE only.
REQ-028 SHALL drive gat_debug = {run_cnt[15:0], zero pad, done_q, load_err, state[2:0]}, with run_cnt incrementing on each RUN->DONE and wrapping at 16 bits.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-RUN, immediately place the FSM in IDLE and clear done_q, load_err, run_cnt, core_layer, load_cnt and all core_* outputs, with core_start=0 and gat_ready=0.
REQ-030 SHALL clear load_err only by reset.

Configuration
REQ-031 SHALL, with macro GAT_LOAD_CNT_EN defined, count accepted writes per channel in load_cnt, saturating at 2^CNT_W-1 and clearing on each entry to LOAD.
REQ-032 SHALL, without GAT_LOAD_CNT_EN, keep the load_cnt port but tie it constant 0 and synthesise no counters.

Verification
REQ-033 SHALL verify: ch0 write at byte address 0x10, data 0xABCDEF -> next cycle core_addra[0]=0x4, core_din[0]=0xABCDEF, core_wea[0]=1.
REQ-034 SHALL verify: load_done pulses 3'b001, then 3'b010, then 3'b100 on separate cycles -> exactly one core_start pulse, issued the cycle after the last pulse.
REQ-035 SHALL verify: ch1 write at byte address 0x6 -> write dropped, load_err=1, gat_debug[3]=1.
REQ-036 SHALL verify: write during RUN -> core_ena=0; core_done -> gat_ready=1 and gat_debug[31:16]=1.
REQ-037 SHALL verify: rst_n low for 1 cycle mid-RUN -> state IDLE, gat_ready=0, core_start=0 and load_cnt=0.
REQ-038 SHALL verify: with GAT_LOAD_CNT_EN defined, 5 aligned writes on ch2 -> load_cnt[2]=5.
